// File: rtl/aes_inv_keyschedule_if.sv
// Key-request and round-key stream bundle between the decrypt control and the AES-128 inverse key scheduler.
`timescale 1ns/1ps
interface aes_inv_keyschedule_if;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] subkey_out;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  key_valid, subkey_out, round_idx, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output key_valid, subkey_out, round_idx, busy, done
  );
endinterface

// File: rtl/aes_inv_keyschedule.sv
// AES-128 inverse key scheduler: 10 forward steps to reach K10, then K10..K0 in reverse order, one key per cycle.
// First key_valid 10 cycles after start; when key_ready is low, key_valid, subkey_out and round_idx hold.
`timescale 1ns/1ps
module aes_inv_keyschedule #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aes_inv_keyschedule_if.slave    ks
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_inv_keyschedule supports only NR = 10");
  end

  localparam logic [3:0] LAST_STEP = 4'(NR - 1);

  // Row-major S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    logic [8:0] tmp;
    tmp = {1'b0, b} ^ (b[0] ? 9'h11b : 9'h000);
    return tmp[8:1];
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  state_t       state_q;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;
  logic         done_q;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w3_inv, sub_in, rot_word, sub_word, t_word;
  logic [31:0] f0, f1, f2, f3;
  logic [127:0] key_fwd, key_inv;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // One SubWord serves both directions: going backwards, the word it needs is the regenerated w3.
  assign w3_inv   = w3 ^ w2;
  assign sub_in   = (state_q == EMIT) ? w3_inv : w3;
  assign rot_word = {sub_in[23:0], sub_in[31:24]};
  assign sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                     sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
  assign t_word   = sub_word ^ {rcon_q, 24'h000000};

  assign f0 = w0 ^ t_word;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign key_fwd = {f0, f1, f2, f3};
  assign key_inv = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3_inv};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ks.start) begin
            state_q <= EXPAND;
            key_q   <= ks.key_in;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
          end
        end
        EXPAND: begin
          key_q   <= key_fwd;
          round_q <= round_q + 4'd1;
          // rcon stays at the last forward value; the first backward step reuses it.
          if (round_q == LAST_STEP) begin
            state_q <= EMIT;
          end else begin
            rcon_q <= xtime(rcon_q);
          end
        end
        EMIT: begin
          if (ks.key_ready) begin
            if (round_q != 4'd0) begin
              key_q   <= key_inv;
              round_q <= round_q - 4'd1;
              rcon_q  <= inv_xtime(rcon_q);
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ks.key_valid  = (state_q == EMIT);
  assign ks.subkey_out = key_q;
  assign ks.round_idx  = round_q;
  assign ks.busy       = (state_q != IDLE);
  assign ks.done       = done_q;

endmodule

// File: tb/tb_aes_inv_keyschedule.sv
// Directed and randomized checks of the reverse round-key stream against an independent forward-expansion model.
`timescale 1ns/1ps
module tb_aes_inv_keyschedule;

  logic clk;
  logic rst_n;

  aes_inv_keyschedule_if ks_if ();

  aes_inv_keyschedule #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks_if.slave)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb     [0:255];
  logic [127:0] ref_rk [0:10];
  logic [127:0] cap    [0:10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // S-box rebuilt from GF(2^8) inversion and the affine map, independent of any table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p, e;
    r = 8'h01; p = a; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] s, t;
    s = b; t = b;
    for (int k = 1; k <= 4; k++) begin
      t = {t[6:0], t[7]};
      s = s ^ t;
    end
    return s ^ 8'h63;
  endfunction

  task automatic ref_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 128'(ks_if.key_valid), 128'd0);
    chk({tag, "_busy"},  128'(ks_if.busy),      128'd0);
    chk({tag, "_done"},  128'(ks_if.done),      128'd0);
    chk({tag, "_key"},   ks_if.subkey_out,      128'd0);
    chk({tag, "_idx"},   128'(ks_if.round_idx), 128'd0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: random ready plus ignored start pulses.
  task automatic run_key(input logic [127:0] key, input int mode, input bit b2b);
    int cyc;
    int r;
    bit rdy;
    ref_expand(key);
    ks_if.start     = 1'b1;
    ks_if.key_in    = key;
    ks_if.key_ready = (mode == 0);
    tick();
    ks_if.start  = 1'b0;
    ks_if.key_in = ~key;
    chk("busy_expand", 128'(ks_if.busy), 128'd1);
    cyc = 0;
    while (!ks_if.key_valid && cyc < 20) begin
      ks_if.start = (mode == 2 && cyc == 4);
      tick();
      cyc++;
    end
    ks_if.start = 1'b0;
    chk("latency", 128'(cyc), 128'd10);
    r = 10;
    cyc = 0;
    while (r >= 0 && cyc < 400) begin
      chk("valid",    128'(ks_if.key_valid), 128'd1);
      chk("done_low", 128'(ks_if.done),      128'd0);
      chk("idx",      128'(ks_if.round_idx), 128'(r));
      chk("subkey",   ks_if.subkey_out,      ref_rk[r]);
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ks_if.key_ready = rdy;
      ks_if.start     = (mode == 2 && r == 5);
      if (rdy) cap[r] = ks_if.subkey_out;
      tick();
      cyc++;
      if (rdy) r--;
    end
    ks_if.start     = 1'b0;
    ks_if.key_ready = 1'b0;
    chk("all_keys_sent", 128'(r + 1), 128'd0);
    chk("done_pulse",    128'(ks_if.done),      128'd1);
    chk("valid_drop",    128'(ks_if.key_valid), 128'd0);
    chk("busy_fall",     128'(ks_if.busy),      128'd0);
    if (!b2b) begin
      tick();
      chk("done_one_cycle", 128'(ks_if.done), 128'd0);
    end
  endtask

  initial begin
    logic [127:0] rkey;
    int guard;
    for (int i = 0; i < 256; i++) sb[i] = affine(ginv(8'(i)));

    rst_n           = 1'b0;
    ks_if.start     = 1'b0;
    ks_if.key_in    = '0;
    ks_if.key_ready = 1'b0;
    #12;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // FIPS-197 key, full-rate consumer
    run_key(FIPS_KEY, 0, 1'b0);
    chk("fips_k10", cap[10], FIPS_K10);
    chk("fips_k9",  cap[9],  FIPS_K9);
    chk("fips_k0",  cap[0],  FIPS_KEY);

    // stalling consumer, then stalling consumer with ignored restarts
    run_key(FIPS_KEY, 1, 1'b0);
    chk("stall_k10", cap[10], FIPS_K10);
    run_key(FIPS_KEY, 2, 1'b0);
    chk("restart_k10", cap[10], FIPS_K10);
    chk("restart_k0",  cap[0],  FIPS_KEY);

    // asynchronous reset in the middle of the stream
    ks_if.start     = 1'b1;
    ks_if.key_in    = FIPS_KEY;
    ks_if.key_ready = 1'b1;
    tick();
    ks_if.start = 1'b0;
    guard = 0;
    while (!(ks_if.key_valid && ks_if.round_idx == 4'd5) && guard < 40) begin
      tick();
      guard++;
    end
    chk("mid_emit_idx", 128'(ks_if.round_idx), 128'd5);
    ks_if.key_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    tick();
    chk("rst_no_done", 128'(ks_if.done), 128'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", 128'(ks_if.busy), 128'd0);
    run_key(SEQ_KEY, 0, 1'b0);
    chk("seq_k10", cap[10], SEQ_K10);

    // back-to-back: second start issued in the done cycle
    run_key(SEQ_KEY, 0, 1'b1);
    run_key(FIPS_KEY, 0, 1'b0);
    chk("b2b_k10", cap[10], FIPS_K10);
    chk("b2b_k0",  cap[0],  FIPS_KEY);

    // random keys against the reference model
    for (int k = 0; k < 1000; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_key(rkey, (k % 8 == 0) ? 1 : 0, 1'b1);
    end
    tick();
    chk("final_done_low", 128'(ks_if.done), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_keyschedule.md
Name: aes_inv_keyschedule

Overview:
Iterative AES-128 key scheduler for the decryption datapath. It accepts the cipher key and runs forward expansion to obtain round key K10. It then streams round keys in reverse order (K10, K9, … K0) over a valid/ready handshake to the decryption-side key addition stage. It stores only one 128-bit round key and regenerates each previous key with the inverse key-schedule step.

Parameters:
NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a configuration error.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; samples key_in; accepted only in IDLE
key_in  in  128  cipher key K0; bits [127:96] = word w0, [31:0] = w3
key_ready  in  1  consumer accepts subkey_out this cycle
key_valid  out  1  subkey_out/round_idx valid
subkey_out  out  128  current round key, same word order as key_in
round_idx  out  4  index of subkey_out (10 down to 0)
busy  out  1  high in EXPAND and EMIT
done  out  1  one-cycle pulse after K0 is accepted

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; key register=0; round=0; rcon=8'h01.
  - key_valid=0, busy=0, done=0; subkey_out=0; round_idx=0.
- States:
  - IDLE -> EXPAND on start. Start is ignored in EXPAND/EMIT.
  - EXPAND -> EMIT after NR steps.
  - EMIT -> IDLE when K0 is accepted.
- Start edge:
  - key register <= key_in; round <= 0; rcon <= 8'h01.
- EXPAND, one forward step per edge:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - round++; rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1b : 0).
  - On the 10th step: state <= EMIT, round=10, rcon=8'h36.
  - key_valid rises exactly 10 cycles after the start edge.
- EMIT:
  - key_valid=1; subkey_out = key register; round_idx = round.
  - Transfer occurs on key_valid & key_ready.
  - Transfer with round>0, one inverse step on the same edge:
    - w3' = w3 ^ w2; w2' = w2 ^ w1; w1' = w1 ^ w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon,24'h0}
    - round--; rcon <= inverse xtime: rcon[0] ? ((rcon ^ 9'h11b) >> 1) : rcon >> 1.
    - Example: 8'h1b -> 8'h80.
  - Sustained throughput is one key per cycle while key_ready=1.
  - Transfer with round==0: state <= IDLE; done=1 for one cycle; key_valid drops the next cycle.
  - No transfer: all outputs hold stable (valid must not drop, data must not change).
- Datapath sharing: a single 4-byte SubWord block, fed by a mux.
  - EXPAND input: w3.
  - EMIT input: w3 ^ w2.
  - S-box implemented as a combinational 256-entry function.
- busy = (state != IDLE). done is registered.
- Reset mid-EXPAND or mid-EMIT aborts immediately; no done pulse. A fresh start is required.
- start in the same cycle as the final K0 transfer is ignored (state is not IDLE when sampled).

Test Plan:
1. FIPS-197 App. A key 2b7e151628aed2a6abf7158809cf4f3c, start, key_ready=1 -> key_valid rises 10 cycles after start. Keys appear on consecutive cycles:
   - round_idx 10: subkey_out=d014f9a8c9ee2589e13f0cc8b6630ca6
   - round_idx 9: ac7766f319fadc2128d12941575c006e
   - round_idx 0: 2b7e1516…09cf4f3c
   - done pulses once after K0; busy falls.
2. Same key, key_ready toggled pseudo-randomly -> subkey_out/round_idx stay stable while key_valid & !key_ready. Sequence identical to scenario 1; no keys skipped or duplicated.
3. start re-pulsed during EXPAND and during EMIT with a different key_in -> ignored; output sequence still matches the first key.
4. rst_n asserted mid-EMIT at round_idx=5 -> outputs zero asynchronously with no done pulse. A new start with key 000102…0e0f -> K10 = 13111d7fe3944a17f307a78b4d2b30c5.
5. Back-to-back: start asserted the cycle after done -> accepted. Second run produces the correct K10…K0 for the new key.
6. Random keys vs reference model (forward expansion, reversed) -> all 11 round keys match for 1000 keys.
